ladybird_bus_arbiter: RTL and testbench
=======================================

# ladybird_bus_arbiter

Two-requester to one-bus memory arbiter that lets the instruction-fetch port and the data (MMU) port of the core share a single memory bus. It forwards one request per cycle with round-robin fairness and locks the selection while a request is stalled. It tracks up to MAX_OUTSTANDING accepted transactions in an owner FIFO and steers each in-order response back to the port that issued it. It sits between the core/MMU bus masters and the single memory/interconnect slave.

## Interface
Parameters:
- XLEN, 32, address/data width.
- MAX_OUTSTANDING, 2, owner-FIFO depth; must be a power of two, at least 1.

Ports:
- clk  in  1  clock.
- anrst  in  1  asynchronous active-low reset.
- nrst  in  1  synchronous active-low reset, sampled on clk.
- p0_req / p1_req  in  1  request valid; port 0 is instruction fetch, port 1 is data.
- p0_addr / p1_addr  in  XLEN  request address.
- p0_wdata / p1_wdata  in  XLEN  write data.
- p0_wstrb / p1_wstrb  in  XLEN/8  byte strobes; all zero means read.
- p0_gnt / p1_gnt  out  1  request accepted this cycle.
- p0_data_gnt / p1_data_gnt  out  1  response for this port this cycle.
- p0_rdata / p1_rdata  out  XLEN  read data, which is mem_rdata broadcast to both ports.
- mem_req  out  1  request to the memory bus.
- mem_addr, mem_wdata, mem_wstrb  out  XLEN, XLEN, XLEN/8  muxed from the selected port.
- mem_gnt  in  1  the memory bus accepts the request.
- mem_data_gnt  in  1  memory response, one per accepted request (writes included), delivered in order.
- mem_rdata  in  XLEN  response data.
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current owner-FIFO occupancy.
- protocol_error  out  1  sticky; set when a response arrives with the FIFO empty.

## Operation
- Handshake: a request transfers on a port when req & gnt are both high. The accepted transfer is mem_req & mem_gnt in the same cycle.
- Selection:
  - Only one port requesting: that port is selected.
  - Both ports requesting: the port other than last_grant is selected.
  - last_grant updates only on a handshake, to the port that completed it.
- Lock:
  - The lock is set when mem_req is high and mem_gnt is low. It holds lock_port, the port selected that cycle.
  - While the lock is set, the selection is forced to lock_port, regardless of the other port.
  - The lock clears on a handshake.
  - The lock also clears if the lock_port deasserts req. Selection then restarts the same cycle from the remaining requester.
- mem_req = (p0_req | p1_req) & ~full. The mem_addr, mem_wdata and mem_wstrb outputs come from the selected port. When idle, they are driven from port 0.
- pN_gnt = mem_gnt & mem_req & (sel == N).
- Owner FIFO:
  - Push: the selected port ID on each handshake.
  - Pop: on each mem_data_gnt while non-empty.
  - pN_data_gnt = mem_data_gnt & ~empty & (head == N).
- Full: mem_req is held low, even when a pop occurs in the same cycle. This gives a fixed one-cycle bubble.
- Simultaneous push and pop when not full: occupancy is unchanged, and head and tail both advance.
- Empty with mem_data_gnt high: the response is dropped, no pN_data_gnt is raised, and protocol_error is set until reset.
- Pointer arithmetic: the pointers are $clog2(MAX_OUTSTANDING) bits and wrap modulo the depth. Occupancy saturates at neither end; over- and underflow are prevented by the rules above.

## Timing
- Request and response paths are combinational: zero added latency, req→mem_req and mem_gnt→pN_gnt in the same cycle.
- State registers: last_grant, lock, lock_port, the FIFO entries, the pointers, occupancy, protocol_error.
- Reset, anrst low (asynchronous) or nrst low at a clk edge:
  - last_grant=1, so port 0 wins the first tie.
  - lock=0, FIFO empty, outstanding=0, protocol_error=0.
- While anrst or nrst is low: mem_req, p0_gnt, p1_gnt, p0_data_gnt and p1_data_gnt are forced to 0.
- Reset mid-transaction discards the owner FIFO. Responses arriving after reset hit the empty case.

## Test plan
- Single port 0 read, addr 0x100: mem_req in the same cycle; mem_gnt=1 → p0_gnt=1, outstanding=1. The response 2 cycles later with rdata 0xDEADBEEF → p0_data_gnt=1 only, outstanding=0.
- Both ports requesting every cycle, mem_gnt=1, after reset: the grant order is p0, p1, p0, p1. Responses return to the owners in the same order.
- Lock: p1 requests alone and mem_gnt is held low for 3 cycles; p0 raises req in cycle 2. mem_addr stays equal to p1_addr until p1_gnt, and p0 is granted the cycle after.
- Full, MAX_OUTSTANDING=2: two handshakes with no responses → mem_req=0 while p0_req=1. Then mem_data_gnt → pop, mem_req still 0 that cycle and 1 the next.
- mem_data_gnt with the FIFO empty: no pN_data_gnt, and protocol_error goes high and stays high until nrst.
- With outstanding=1, assert anrst low mid-cycle: all outputs go to reset values immediately. After release, outstanding=0.

Source files
------------

// File: rtl/ladybird_bus_arbiter.sv
// Two-port round-robin arbiter onto one memory bus, with selection lock while stalled
// and an owner FIFO that routes in-order responses back to the issuing port.
module ladybird_bus_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                               clk,
  input  logic                               anrst,
  input  logic                               nrst,
  input  logic                               p0_req,
  input  logic [XLEN-1:0]                    p0_addr,
  input  logic [XLEN-1:0]                    p0_wdata,
  input  logic [XLEN/8-1:0]                  p0_wstrb,
  output logic                               p0_gnt,
  output logic                               p0_data_gnt,
  output logic [XLEN-1:0]                    p0_rdata,
  input  logic                               p1_req,
  input  logic [XLEN-1:0]                    p1_addr,
  input  logic [XLEN-1:0]                    p1_wdata,
  input  logic [XLEN/8-1:0]                  p1_wstrb,
  output logic                               p1_gnt,
  output logic                               p1_data_gnt,
  output logic [XLEN-1:0]                    p1_rdata,
  output logic                               mem_req,
  output logic [XLEN-1:0]                    mem_addr,
  output logic [XLEN-1:0]                    mem_wdata,
  output logic [XLEN/8-1:0]                  mem_wstrb,
  input  logic                               mem_gnt,
  input  logic                               mem_data_gnt,
  input  logic [XLEN-1:0]                    mem_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               protocol_error
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic             active;
  logic             last_grant;
  logic             lock;
  logic             lock_port;
  logic             lock_live;
  logic             sel;
  logic             owner_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             head;
  logic             handshake;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Either reset being low silences every handshake-type output immediately.
  assign active    = anrst & nrst;
  assign full      = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty     = (count == '0);
  assign head      = owner_q[rd_ptr];
  assign lock_live = lock & (lock_port ? p1_req : p0_req);

  // A dropped lock falls through to normal round-robin in the same cycle.
  always_comb begin
    sel = 1'b0;
    if (lock_live)
      sel = lock_port;
    else if (p0_req && p1_req)
      sel = ~last_grant;
    else if (p1_req)
      sel = 1'b1;
  end

  assign mem_req   = active & (p0_req | p1_req) & ~full;
  assign mem_addr  = sel ? p1_addr  : p0_addr;
  assign mem_wdata = sel ? p1_wdata : p0_wdata;
  assign mem_wstrb = sel ? p1_wstrb : p0_wstrb;
  assign handshake = mem_req & mem_gnt;
  assign p0_gnt    = handshake & ~sel;
  assign p1_gnt    = handshake & sel;

  assign pop         = active & mem_data_gnt & ~empty;
  assign p0_data_gnt = pop & ~head;
  assign p1_data_gnt = pop & head;
  assign p0_rdata    = mem_rdata;
  assign p1_rdata    = mem_rdata;
  assign outstanding = count;

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      last_grant     <= 1'b1;
      lock           <= 1'b0;
      lock_port      <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      protocol_error <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) owner_q[i] <= 1'b0;
    end else if (!nrst) begin
      last_grant     <= 1'b1;
      lock           <= 1'b0;
      lock_port      <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      protocol_error <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) owner_q[i] <= 1'b0;
    end else begin
      if (handshake) begin
        last_grant      <= sel;
        owner_q[wr_ptr] <= sel;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      case ({handshake, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Stalled requests pin the selection; a handshake or a withdrawn request frees it.
      if (handshake) begin
        lock <= 1'b0;
      end else if (mem_req && !mem_gnt) begin
        lock      <= 1'b1;
        lock_port <= sel;
      end else begin
        lock <= lock_live;
      end
      if (mem_data_gnt && empty)
        protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// Scoreboard bench for ladybird_bus_arbiter: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_ladybird_bus_arbiter;

  localparam int XLEN = 32;
  localparam int MAXO = 2;

  logic              clk;
  logic              anrst;
  logic              nrst;
  logic              p0_req, p1_req;
  logic [XLEN-1:0]   p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic [XLEN/8-1:0] p0_wstrb, p1_wstrb;
  logic              p0_gnt, p1_gnt, p0_data_gnt, p1_data_gnt;
  logic [XLEN-1:0]   p0_rdata, p1_rdata;
  logic              mem_req;
  logic [XLEN-1:0]   mem_addr, mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic              mem_gnt, mem_data_gnt;
  logic [XLEN-1:0]   mem_rdata;
  logic [$clog2(MAXO):0] outstanding;
  logic              protocol_error;

  ladybird_bus_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .anrst(anrst), .nrst(nrst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
    .p0_gnt(p0_gnt), .p0_data_gnt(p0_data_gnt), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
    .p1_gnt(p1_gnt), .p1_data_gnt(p1_data_gnt), .p1_rdata(p1_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_data_gnt(mem_data_gnt), .mem_rdata(mem_rdata),
    .outstanding(outstanding), .protocol_error(protocol_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          mem_req;
    bit          g0, g1, d0, d1;
    logic [31:0] addr;
    int          outst;
    bit          perr;
  } cyc_t;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } gnt_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
  } rsp_t;

  cyc_t cyc_q[$];
  gnt_t grant_q[$];
  rsp_t resp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: who won last, which port (if any) holds the lock, owners in flight.
  int m_last = 1;
  int m_lock = -1;
  int m_owner[$];
  bit m_perr = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: DUT output with no expectation queued at %0t", name, $time);
  endtask

  task automatic modelReset();
    m_last = 1;
    m_lock = -1;
    m_owner.delete();
    m_perr = 1'b0;
  endtask

  task automatic applyStimulus(input bit r0, input bit r1, input logic [31:0] a0,
                               input logic [31:0] a1, input bit mg, input bit mdg,
                               input bit nr, input logic [31:0] rd,
                               output bit hs0, output bit hs1);
    cyc_t e;
    gnt_t g;
    rsp_t rs;
    int   sel;
    int   pre;
    bit   locked;
    bit   hs;
    @(posedge clk);
    #1;
    p0_req = r0;  p0_addr = a0;  p0_wdata = ~a0;              p0_wstrb = 4'h0;
    p1_req = r1;  p1_addr = a1;  p1_wdata = a1 ^ 32'h5a5a5a5a; p1_wstrb = a1[7:4];
    mem_gnt = mg; mem_data_gnt = mdg; mem_rdata = rd; nrst = nr;
    hs0 = 1'b0;
    hs1 = 1'b0;
    e.addr  = 32'h0;
    e.outst = m_owner.size();
    e.perr  = m_perr;
    if (!nr) begin
      e.mem_req = 0; e.g0 = 0; e.g1 = 0; e.d0 = 0; e.d1 = 0;
      cyc_q.push_back(e);
      modelReset();
    end else begin
      pre    = m_owner.size();
      locked = (m_lock == 0 && r0) || (m_lock == 1 && r1);
      if (locked)        sel = m_lock;
      else if (r0 && r1) sel = 1 - m_last;
      else if (r1)       sel = 1;
      else               sel = 0;
      e.mem_req = (r0 || r1) && (pre < MAXO);
      hs        = e.mem_req && mg;
      e.g0      = hs && (sel == 0);
      e.g1      = hs && (sel == 1);
      e.addr    = (sel == 1) ? a1 : a0;
      e.d0      = mdg && (pre > 0) && (m_owner[0] == 0);
      e.d1      = mdg && (pre > 0) && (m_owner[0] == 1);
      cyc_q.push_back(e);
      if (mdg && pre > 0) begin
        rs.port  = m_owner.pop_front();
        rs.rdata = rd;
        resp_q.push_back(rs);
      end
      if (mdg && pre == 0) m_perr = 1'b1;
      if (hs) begin
        g.port  = sel;
        g.addr  = (sel == 1) ? a1 : a0;
        g.wdata = (sel == 1) ? (a1 ^ 32'h5a5a5a5a) : ~a0;
        g.wstrb = (sel == 1) ? a1[7:4] : 4'h0;
        grant_q.push_back(g);
        m_owner.push_back(sel);
        m_last = sel;
        m_lock = -1;
        hs0 = (sel == 0);
        hs1 = (sel == 1);
      end else if (e.mem_req && !mg) begin
        m_lock = sel;
      end else if (!locked) begin
        m_lock = -1;
      end
    end
  endtask

  // Monitor: one cycle expectation per driven cycle, plus transaction-level grant/response matching.
  cyc_t mon_e;
  gnt_t mon_g;
  rsp_t mon_r;
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      mon_e = cyc_q.pop_front();
      checkOutput("mem_req", {31'b0, mem_req}, {31'b0, mon_e.mem_req});
      checkOutput("p0_gnt", {31'b0, p0_gnt}, {31'b0, mon_e.g0});
      checkOutput("p1_gnt", {31'b0, p1_gnt}, {31'b0, mon_e.g1});
      checkOutput("p0_data_gnt", {31'b0, p0_data_gnt}, {31'b0, mon_e.d0});
      checkOutput("p1_data_gnt", {31'b0, p1_data_gnt}, {31'b0, mon_e.d1});
      checkOutput("outstanding", 32'(outstanding), 32'(mon_e.outst));
      checkOutput("protocol_error", {31'b0, protocol_error}, {31'b0, mon_e.perr});
      if (mon_e.mem_req) checkOutput("mem_addr", mem_addr, mon_e.addr);
      if (p0_gnt || p1_gnt) begin
        if (grant_q.size() == 0) failNow("grant_scoreboard");
        else begin
          mon_g = grant_q.pop_front();
          checkOutput("grant_port", p1_gnt ? 32'd1 : 32'd0, 32'(mon_g.port));
          checkOutput("grant_addr", mem_addr, mon_g.addr);
          checkOutput("grant_wdata", mem_wdata, mon_g.wdata);
          checkOutput("grant_wstrb", {28'b0, mem_wstrb}, {28'b0, mon_g.wstrb});
        end
      end
      if (p0_data_gnt || p1_data_gnt) begin
        if (resp_q.size() == 0) failNow("resp_scoreboard");
        else begin
          mon_r = resp_q.pop_front();
          checkOutput("resp_port", p1_data_gnt ? 32'd1 : 32'd0, 32'(mon_r.port));
          checkOutput("resp_rdata", p1_data_gnt ? p1_rdata : p0_rdata, mon_r.rdata);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  bit h0, h1;
  bit pend0, pend1;
  logic [31:0] ad0, ad1;

  initial begin
    anrst = 1'b0; nrst = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1;
    p0_addr = 32'h40; p1_addr = 32'h80;
    p0_wdata = '0; p1_wdata = '0; p0_wstrb = '0; p1_wstrb = '0;
    mem_gnt = 1'b1; mem_data_gnt = 1'b1; mem_rdata = '0;
    #8;
    checkOutput("reset_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("reset_p0_gnt", {31'b0, p0_gnt}, 32'd0);
    checkOutput("reset_p0_data_gnt", {31'b0, p0_data_gnt}, 32'd0);
    checkOutput("reset_outstanding", 32'(outstanding), 32'd0);
    checkOutput("reset_protocol_error", {31'b0, protocol_error}, 32'd0);
    p0_req = 1'b0; p1_req = 1'b0; mem_gnt = 1'b0; mem_data_gnt = 1'b0;
    #4;
    anrst = 1'b1; nrst = 1'b1;
    modelReset();

    // Single port-0 read, response two cycles later.
    applyStimulus(1, 0, 32'h100, 32'h0, 1, 0, 1, 32'h0, h0, h1);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h0, h0, h1);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h0, h0, h1);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 1, 32'hDEADBEEF, h0, h1);

    // Synchronous reset with both requesting, then alternating ties.
    applyStimulus(1, 1, 32'h200, 32'h300, 1, 0, 0, 32'h0, h0, h1);
    applyStimulus(1, 1, 32'h204, 32'h304, 1, 0, 1, 32'h0, h0, h1);
    applyStimulus(1, 1, 32'h208, 32'h308, 1, 1, 1, 32'h11111111, h0, h1);
    applyStimulus(1, 1, 32'h20c, 32'h30c, 1, 1, 1, 32'h22222222, h0, h1);
    applyStimulus(1, 1, 32'h210, 32'h310, 1, 1, 1, 32'h33333333, h0, h1);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 1, 32'h44444444, h0, h1);

    // Lock on port 1 while stalled, port 0 joins in cycle 2.
    applyStimulus(0, 1, 32'h400, 32'h500, 0, 0, 1, 32'h0, h0, h1);
    applyStimulus(1, 1, 32'h400, 32'h500, 0, 0, 1, 32'h0, h0, h1);
    applyStimulus(1, 1, 32'h400, 32'h500, 0, 0, 1, 32'h0, h0, h1);
    applyStimulus(1, 1, 32'h400, 32'h500, 1, 0, 1, 32'h0, h0, h1);
    applyStimulus(1, 0, 32'h400, 32'h0, 1, 0, 1, 32'h0, h0, h1);

    // Full: bubble on the pop cycle, request resumes the cycle after.
    applyStimulus(1, 0, 32'h600, 32'h0, 1, 0, 1, 32'h0, h0, h1);
    applyStimulus(1, 0, 32'h600, 32'h0, 1, 1, 1, 32'h55555555, h0, h1);
    applyStimulus(1, 0, 32'h600, 32'h0, 1, 0, 1, 32'h0, h0, h1);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 1, 32'h66666666, h0, h1);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 1, 32'h77777777, h0, h1);

    // Response with nothing in flight: sticky error until synchronous reset.
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 1, 32'h88888888, h0, h1);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h0, h0, h1);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h0, h0, h1);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, h0, h1);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h0, h0, h1);

    // Random traffic; masters usually hold a request until granted.
    pend0 = 0; pend1 = 0; ad0 = '0; ad1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend0 && $urandom_range(0, 99) < 50) begin
        pend0 = 1; ad0 = $urandom & 32'hFFFF_FFFC;
      end else if (pend0 && $urandom_range(0, 99) < 8) pend0 = 0;
      if (!pend1 && $urandom_range(0, 99) < 50) begin
        pend1 = 1; ad1 = $urandom & 32'hFFFF_FFFC;
      end else if (pend1 && $urandom_range(0, 99) < 8) pend1 = 0;
      applyStimulus(pend0, pend1, ad0, ad1, $urandom_range(0, 99) < 60,
                    (m_owner.size() > 0) && ($urandom_range(0, 99) < 50), 1, $urandom, h0, h1);
      if (h0) pend0 = 0;
      if (h1) pend1 = 0;
    end
    for (int i = 0; i < 4 && m_owner.size() > 0; i++)
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 1, $urandom, h0, h1);

    // Asynchronous reset mid-cycle with one transaction outstanding.
    applyStimulus(1, 0, 32'h700, 32'h0, 1, 0, 1, 32'h0, h0, h1);
    @(posedge clk);
    #1;
    p0_req = 1'b1; p0_addr = 32'h704; mem_gnt = 1'b1; mem_data_gnt = 1'b0;
    #1;
    checkOutput("pre_anrst_outstanding", 32'(outstanding), 32'd1);
    #1;
    anrst = 1'b0;
    #1;
    checkOutput("anrst_mem_req", {31'b0, mem_req}, 32'd0);
    checkOutput("anrst_p0_gnt", {31'b0, p0_gnt}, 32'd0);
    checkOutput("anrst_outstanding", 32'(outstanding), 32'd0);
    #3;
    p0_req = 1'b0; mem_gnt = 1'b0;
    anrst = 1'b1;
    modelReset();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h0, h0, h1);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 1, 32'h99999999, h0, h1);
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h0, h0, h1);

    @(negedge clk);
    #1;
    checkOutput("leftover_cycles", 32'(cyc_q.size()), 32'd0);
    checkOutput("leftover_grants", 32'(grant_q.size()), 32'd0);
    checkOutput("leftover_responses", 32'(resp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
